// File: rtl/risc_toy_pkg.sv
// Shared constants for the RISC_TOY core family: datapath widths, reset vector and the
// opcode encodings that fetch and decode agree on.
package risc_toy_pkg;

  localparam int unsigned RISC_TOY_AW       = 30;
  localparam int unsigned RISC_TOY_DW       = 32;
  localparam int unsigned RISC_TOY_RESET_PC = 0;

  localparam logic [5:0] OP_ALU    = 6'h00;
  localparam logic [5:0] OP_ALUI   = 6'h01;
  localparam logic [5:0] OP_LOAD   = 6'h02;
  localparam logic [5:0] OP_STORE  = 6'h03;
  localparam logic [5:0] OP_BRANCH = 6'h04;
  localparam logic [5:0] OP_JUMP   = 6'h05;
  localparam logic [5:0] OP_JALR   = 6'h06;
  localparam logic [5:0] OP_SYS    = 6'h3f;

endpackage

// File: rtl/risc_toy_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; clear empties it in one cycle and
// takes priority over push and pop.
module risc_toy_fetch_queue
  import risc_toy_pkg::*;
#(
  parameter int unsigned WIDTH = RISC_TOY_AW + RISC_TOY_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    count_d = count_q;
    unique case ({push, do_pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // The upstream issue gate must never let a push land on a full queue.
      if (push) begin
        assert (count_q != (PW + 1)'(DEPTH));
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/risc_toy_fetch.sv
// Instruction-fetch front end: one-in-flight request tracker feeding a prefetch queue, with a
// ready/valid handshake to decode and a redirect port that flushes and restarts fetch.
module risc_toy_fetch
  import risc_toy_pkg::*;
#(
  parameter int unsigned AW       = RISC_TOY_AW,
  parameter int unsigned DW       = RISC_TOY_DW,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = RISC_TOY_RESET_PC
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [DW-1:0] INSTR,
  input  logic          REDIRECT,
  input  logic [AW-1:0] REDIRECT_ADDR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_INSTR,
  output logic [AW-1:0] OUT_PC
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    fetch_pc_q, inflight_pc_q;
  logic             inflight_q;
  logic [CW-1:0]    count;
  logic [AW+DW-1:0] head;
  logic [CW:0]      occupancy;
  logic             push, pop, valid;

  always_comb begin
    // Queued plus in-flight entries bound the issue so a response always has a free slot.
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    IREQ      = !RST && !REDIRECT && (occupancy < (CW + 1)'(DEPTH));
    IADDR     = RST ? AW'(RESET_PC) : fetch_pc_q;
    valid     = !RST && (count != '0);
    OUT_VALID = valid;
    OUT_PC    = valid ? head[AW+DW-1:DW] : '0;
    OUT_INSTR = valid ? head[DW-1:0] : '0;
    push      = inflight_q && !REDIRECT;
    pop       = valid && OUT_READY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q    <= AW'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (REDIRECT) begin
      fetch_pc_q <= REDIRECT_ADDR;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= IREQ;
      if (IREQ) begin
        fetch_pc_q    <= fetch_pc_q + AW'(1);
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  risc_toy_fetch_queue #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (CLK),
    .rst       (RST),
    .clear     (REDIRECT),
    .push      (push),
    .push_data ({inflight_pc_q, INSTR}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed and randomised checks of the fetch front end against an instruction memory that
// returns the bitwise inverse of the zero-extended word address.
module tb_risc_toy_fetch;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          CLK, RST, IREQ, REDIRECT, OUT_VALID, OUT_READY;
  logic [AW-1:0] IADDR, REDIRECT_ADDR, OUT_PC;
  logic [DW-1:0] INSTR, OUT_INSTR;

  int errors = 0;
  int checks = 0;

  risc_toy_fetch #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (4),
    .RESET_PC (0)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IREQ          (IREQ),
    .IADDR         (IADDR),
    .INSTR         (INSTR),
    .REDIRECT      (REDIRECT),
    .REDIRECT_ADDR (REDIRECT_ADDR),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_INSTR     (OUT_INSTR),
    .OUT_PC        (OUT_PC)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return ~{2'b00, a};
  endfunction

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) INSTR <= mem_word(IADDR);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; REDIRECT = 1'b0; OUT_READY = 1'b1;
    step();
    #1;
    checks++; if (IREQ !== 1'b0) begin errors++; $display("FAIL reset_ireq: got %b want 0", IREQ); end
    checks++; if (IADDR !== 30'd0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", IADDR); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
    checks++; if (OUT_INSTR !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", OUT_INSTR); end
    checks++; if (OUT_PC !== 30'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", OUT_PC); end
  endtask

  task automatic test_stream();
    RST = 1'b1; OUT_READY = 1'b1;
    step(); step();
    RST = 1'b0;
    #1;
    checks++; if (IREQ !== 1'b1 || IADDR !== 30'd0) begin
      errors++; $display("FAIL stream_first_req: got ireq=%b addr=%h want 1/0", IREQ, IADDR); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL stream_c0_valid: got %b want 0", OUT_VALID); end
    step(); #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %b want 0", OUT_VALID); end
    step(); #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 30'd0 || OUT_INSTR !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL stream_c2_head: got v=%b pc=%h instr=%h want 1/0/ffffffff",
                         OUT_VALID, OUT_PC, OUT_INSTR); end
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== AW'(i) || OUT_INSTR !== mem_word(AW'(i))) begin
        errors++; $display("FAIL stream_seq%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i,
                           OUT_VALID, OUT_PC, OUT_INSTR, AW'(i), mem_word(AW'(i))); end
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  seen;
    RST = 1'b1; OUT_READY = 1'b0;
    step();
    RST = 1'b0;
    #1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (IREQ) begin
        checks++; if (IADDR !== AW'(n)) begin
          errors++; $display("FAIL bp_addr%0d: got %h want %h", n, IADDR, AW'(n)); end
        n++;
      end
      step(); #1;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", n); end
    OUT_READY = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== AW'(k)) begin
        errors++; $display("FAIL bp_drain%0d: got v=%b pc=%h want 1/%h", k, OUT_VALID, OUT_PC, AW'(k)); end
      if (IREQ && !seen) begin
        seen = 1'b1;
        checks++; if (IADDR !== 30'd4) begin
          errors++; $display("FAIL bp_resume_addr: got %h want 4", IADDR); end
      end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_resume: got no request want one"); end
  endtask

  task automatic test_redirect();
    RST = 1'b1; OUT_READY = 1'b0;
    step();
    RST = 1'b0;
    repeat (4) step();
    // Three entries queued and address 3 in flight.
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h100;
    #1;
    checks++; if (IREQ !== 1'b0) begin errors++; $display("FAIL redir_ireq: got %b want 0", IREQ); end
    step();
    REDIRECT = 1'b0; OUT_READY = 1'b1;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", OUT_VALID); end
    checks++; if (IREQ !== 1'b1 || IADDR !== 30'h100) begin
      errors++; $display("FAIL redir_req: got ireq=%b addr=%h want 1/100", IREQ, IADDR); end
    step(); #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL redir_lat: got %b want 0", OUT_VALID); end
    step(); #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 30'h100 || OUT_INSTR !== mem_word(30'h100)) begin
      errors++; $display("FAIL redir_head: got v=%b pc=%h instr=%h want 1/100/%h",
                         OUT_VALID, OUT_PC, OUT_INSTR, mem_word(30'h100)); end
    step(); #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 30'h101) begin
      errors++; $display("FAIL redir_next: got v=%b pc=%h want 1/101", OUT_VALID, OUT_PC); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp;
    OUT_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_ADDR = 30'h3FFF_FFFE;
    step();
    REDIRECT = 1'b0;
    step(); step();
    exp = 30'h3FFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== exp || OUT_INSTR !== mem_word(exp)) begin
        errors++; $display("FAIL wrap%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i,
                           OUT_VALID, OUT_PC, OUT_INSTR, exp, mem_word(exp)); end
      exp = exp + 30'd1;
      step();
    end
  endtask

  task automatic test_reset_mid();
    RST = 1'b1; OUT_READY = 1'b0;
    step();
    RST = 1'b0;
    repeat (6) step();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL rstmid_full: got %b want 1", OUT_VALID); end
    RST = 1'b1;
    step(); #1;
    checks++; if (OUT_VALID !== 1'b0 || IREQ !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got v=%b ireq=%b want 0/0", OUT_VALID, IREQ); end
    RST = 1'b0;
    #1;
    checks++; if (IREQ !== 1'b1 || IADDR !== 30'd0) begin
      errors++; $display("FAIL rstmid_restart: got ireq=%b addr=%h want 1/0", IREQ, IADDR); end
    OUT_READY = 1'b1;
    step(); step(); #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_PC !== 30'd0 || OUT_INSTR !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rstmid_head: got v=%b pc=%h instr=%h want 1/0/ffffffff",
                         OUT_VALID, OUT_PC, OUT_INSTR); end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp;
    int            pops;
    bit            redir;
    RST = 1'b1; OUT_READY = 1'b0; REDIRECT = 1'b0;
    step();
    RST = 1'b0;
    exp  = '0;
    pops = 0;
    for (int c = 0; c < 10000; c++) begin
      OUT_READY     = ($urandom_range(3) != 0);
      redir         = ($urandom_range(39) == 0);
      REDIRECT      = redir;
      REDIRECT_ADDR = AW'($urandom);
      #1;
      if (redir) begin
        checks++; if (IREQ !== 1'b0) begin
          errors++; $display("FAIL rand_redir_ireq c%0d: got %b want 0", c, IREQ); end
      end
      if (OUT_VALID && OUT_READY) begin
        checks++; if (OUT_PC !== exp) begin
          errors++; $display("FAIL rand_pc c%0d: got %h want %h", c, OUT_PC, exp); end
        checks++; if (OUT_INSTR !== mem_word(exp)) begin
          errors++; $display("FAIL rand_instr c%0d: got %h want %h", c, OUT_INSTR, mem_word(exp)); end
        exp = exp + 30'd1;
        pops++;
      end
      if (redir) exp = REDIRECT_ADDR;
      step();
    end
    REDIRECT = 1'b0;
    checks++; if (pops < 2000) begin errors++; $display("FAIL rand_throughput: got %0d pops want >=2000", pops); end
  endtask

  initial begin
    RST = 1'b1; REDIRECT = 1'b0; REDIRECT_ADDR = '0; OUT_READY = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
